alu_seq: RTL and testbench

Multi-byte sequencer for the 8-bit shared ALU. It accepts one wide operation (add, left shift or right shift on 8×NBYTES-bit operands) and issues it to the ALU one byte per cycle. The carry or shift bit is chained from each byte's sc_o into the next byte's sc_i. The wide result and final carry are captured into registers. It sits between the control unit and the ALU and drives the ALU's command, operand and carry inputs.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and ALU command encodings for the multi-byte ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LSL = 2'b01,
        OP_LSR = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_LSL = 3'b001;
    localparam logic [2:0] ALU_LSR = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic [2:0] alu_cmd_of(op_t op);
        case (op)
            OP_LSL:  return ALU_LSL;
            OP_LSR:  return ALU_LSR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Issues one wide add/shift to the shared 8-bit ALU a byte per cycle,
// chaining carry/shift bits and capturing the wide result and final carry.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    input  logic                  cin,
    input  logic                  abort,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic [2:0]            alu_cmd,
    output logic [7:0]            alu_inA,
    output logic [7:0]            alu_inB,
    output logic                  alu_sc_i,
    input  logic [7:0]            alu_rslt,
    input  logic                  alu_sc_o
);

    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t                   state_q, state_d;
    op_t                      op_q, op_d;
    logic [NBYTES-1:0][7:0]   a_q, a_d;
    logic [NBYTES-1:0][7:0]   b_q, b_d;
    logic [NBYTES-1:0][7:0]   stage_q, stage_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     carry_q, carry_d;
    logic [W-1:0]             result_d;
    logic                     cout_d;
    logic                     err_d;
    logic                     ready_d;
    logic                     done_d;
    logic                     last;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            stage_q <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            stage_q <= stage_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            result  <= result_d;
            cout    <= cout_d;
            err     <= err_d;
            ready   <= ready_d;
            done    <= done_d;
        end
    end

    // Next-state logic; ALU drive depends only on registered state.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        stage_d  = stage_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result;
        cout_d   = cout;
        err_d    = err;
        alu_cmd  = ALU_ADD;
        alu_inA  = 8'h00;
        alu_inB  = 8'h00;
        alu_sc_i = 1'b0;
        last     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_t'(op) == OP_ILL) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        op_d    = op_t'(op);
                        a_d     = opa;
                        b_d     = opb;
                        carry_d = cin;
                        idx_d   = (op_t'(op) == OP_LSR) ? LAST_IDX : '0;
                    end
                end
            end
            RUN: begin
                alu_cmd  = alu_cmd_of(op_q);
                alu_inA  = a_q[idx_q];
                alu_inB  = (op_q == OP_ADD) ? b_q[idx_q] : 8'h00;
                alu_sc_i = carry_q;
                last     = (op_q == OP_LSR) ? (idx_q == '0) : (idx_q == LAST_IDX);
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    stage_d[idx_q] = alu_rslt;
                    carry_d        = alu_sc_o;
                    if (last) begin
                        state_d  = DONE;
                        result_d = stage_d;
                        cout_d   = alu_sc_o;
                    end else if (op_q == OP_LSR) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: bench-side 8-bit ALU, wide-arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned NBYTES = 2;
    localparam int unsigned W      = 8 * NBYTES;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   opa, opb;
    logic           cin, abort;
    logic           ready, done, err, cout;
    logic [W-1:0]   result;
    logic [2:0]     alu_cmd;
    logic [7:0]     alu_inA, alu_inB, alu_rslt;
    logic           alu_sc_i, alu_sc_o;

    alu_seq #(.NBYTES(NBYTES)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .cin(cin), .abort(abort), .ready(ready), .done(done), .err(err),
        .result(result), .cout(cout), .alu_cmd(alu_cmd), .alu_inA(alu_inA),
        .alu_inB(alu_inB), .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o)
    );

    always #5 clk = ~clk;

    // The shared ALU as seen by the sequencer.
    always_comb begin
        logic [8:0] s;
        s = 9'(alu_inA) + 9'(alu_inB) + 9'(alu_sc_i);
        case (alu_cmd)
            3'b001:  {alu_sc_o, alu_rslt} = {alu_inA, alu_sc_i};
            3'b010:  {alu_rslt, alu_sc_o} = {alu_sc_i, alu_inA};
            default: {alu_sc_o, alu_rslt} = s;
        endcase
    end

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         err;
        int unsigned  cyc;
    } exp_t;

    exp_t         sb[$];
    int unsigned  cyc = 0;
    int           total = 0;
    int           passed = 0;
    logic [W-1:0] model_res = '0;
    logic         model_cout = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(done), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("cout", 64'(cout), 64'(e.cout));
                chk("err", 64'(err), 64'(e.err));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Wide reference model: whole-operand arithmetic.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
        logic [W:0] t;
        case (o)
            2'b00: begin
                t = {1'b0, a} + {1'b0, b} + (W+1)'(c);
                model_res = t[W-1:0]; model_cout = t[W];
            end
            2'b01: begin
                t = {a, c};
                model_res = t[W-1:0]; model_cout = t[W];
            end
            2'b10: begin
                t = {c, a};
                model_res = t[W:1]; model_cout = t[0];
            end
            default: ;
        endcase
    endtask

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk({name, "_timeout"}, 64'(ready), 64'(1));
    endtask

    // Entered and left at a negedge; returns in cycle T+1.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input bit expect_done);
        exp_t e;
        wait_ready("issue");
        op = o; opa = a; opb = b; cin = c; start = 1'b1;
        if (expect_done) begin
            model(o, a, b, c);
            e.res  = model_res;
            e.cout = model_cout;
            e.err  = (o == 2'b11);
            e.cyc  = cyc + 1 + ((o == 2'b11) ? 0 : NBYTES);
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0; cin = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_alu_cmd", 64'(alu_cmd), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Add with carry into the second byte.
        issue(2'b00, 16'h12FF, 16'h0001, 1'b0, 1'b1);
        chk("add_cmd", 64'(alu_cmd), 64'(0));
        chk("add_inA0", 64'(alu_inA), 64'h FF);
        chk("add_inB0", 64'(alu_inB), 64'h01);
        chk("add_sc0", 64'(alu_sc_i), 64'(0));
        @(negedge clk);
        chk("add_inA1", 64'(alu_inA), 64'h12);
        chk("add_sc1", 64'(alu_sc_i), 64'(1));
        wait_ready("add1");

        issue(2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b1); wait_ready("add2");
        issue(2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1); wait_ready("add3");
        issue(2'b01, 16'h8001, 16'hFFFF, 1'b1, 1'b1);
        chk("lsl_inB0", 64'(alu_inB), 64'(0));
        wait_ready("lsl");

        // lsr walks bytes from the top down.
        issue(2'b10, 16'h0181, 16'h0000, 1'b1, 1'b1);
        chk("lsr_cmd", 64'(alu_cmd), 64'(2));
        chk("lsr_inA0", 64'(alu_inA), 64'h01);
        @(negedge clk);
        chk("lsr_inA1", 64'(alu_inA), 64'h81);
        wait_ready("lsr");

        issue(2'b11, 16'h1234, 16'h5678, 1'b1, 1'b1); wait_ready("ill");

        // start while busy is dropped.
        issue(2'b00, 16'h0102, 16'h0304, 1'b0, 1'b1);
        start = 1'b1; op = 2'b01; opa = 16'hAAAA;
        @(negedge clk);
        start = 1'b0;
        wait_ready("busy_start");

        // Abort in the first and in the last RUN cycle.
        issue(2'b00, 16'h4444, 16'h1111, 1'b0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort1_ready", 64'(ready), 64'(1));
        chk("abort1_result", 64'(result), 64'(model_res));
        issue(2'b01, 16'h7777, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort2_ready", 64'(ready), 64'(1));
        chk("abort2_result", 64'(result), 64'(model_res));
        chk("abort2_cout", 64'(cout), 64'(model_cout));
        @(negedge clk);

        // Asynchronous reset between edges mid-RUN.
        issue(2'b00, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("areset_ready", 64'(ready), 64'(1));
        chk("areset_done", 64'(done), 64'(0));
        chk("areset_result", 64'(result), 64'(0));
        chk("areset_cout", 64'(cout), 64'(0));
        chk("areset_alu_cmd", 64'(alu_cmd), 64'(0));
        sb.delete();
        model_res = '0; model_cout = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(2'b00, 16'h00F0, 16'h0F10, 1'b1, 1'b1); wait_ready("post_reset");

        // Randomized operations, including illegal ops.
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            wait_ready("rand");
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
